// File: rtl/countdown_timer.sv
// countdown_timer: day/hr/min/sec down-counter with load port, pause and expiry pulse.
// Optional build macro TIMER_AUTO_RELOAD_EN: on expiry restart from the last loaded value.
module countdown_timer #(
   parameter int TICK_DIV = 1,
   parameter int MAX_DAYS = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [4:0] load_day,
   input  logic [4:0] load_hrs,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   output logic       load_err,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [4:0] day,
   output logic [4:0] hrs,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       busy,
   output logic       expired
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [4:0]    r_day, r_hrs;
   logic [5:0]    r_min, r_sec;
   logic [4:0]    w_day_nxt, w_hrs_nxt;
   logic [5:0]    w_min_nxt, w_sec_nxt;
   logic [PW-1:0] r_pre, w_pre_nxt;
   logic          r_expired, w_exp_nxt;
   logic          r_load_err, w_err_nxt;

`ifdef TIMER_AUTO_RELOAD_EN
   logic [4:0]    r_rl_day, r_rl_hrs;
   logic [5:0]    r_rl_min, r_rl_sec;
   logic [4:0]    w_rl_day_nxt, w_rl_hrs_nxt;
   logic [5:0]    w_rl_min_nxt, w_rl_sec_nxt;
   logic          w_rl_nz;
   assign w_rl_nz = |{r_rl_day, r_rl_hrs, r_rl_min, r_rl_sec};
`endif

   logic       w_day_ok;
   logic       w_load_ok;
   logic       w_fire;
   logic       w_nonzero;
   logic       w_le1;
   logic       w_bmin, w_bhrs, w_bday;
   logic [4:0] w_dec_day, w_dec_hrs;
   logic [5:0] w_dec_min, w_dec_sec;

   // A 5-bit day field can never exceed 31, so only a smaller limit needs a compare
   if (MAX_DAYS >= 31) begin : g_day_all
      assign w_day_ok = 1'b1;
   end else begin : g_day_lim
      assign w_day_ok = (load_day <= 5'(MAX_DAYS));
   end

   assign w_load_ok = w_day_ok && (load_hrs <= 5'd23) &&
                      (load_min <= 6'd59) && (load_sec <= 6'd59);
   assign load_ready = (r_state != S_RUN);
   assign w_fire     = load_valid && load_ready;
   assign w_nonzero  = |{r_day, r_hrs, r_min, r_sec};
   assign w_le1      = ({r_day, r_hrs, r_min, r_sec[5:1]} == '0);

   // Borrow chain sec -> min -> hrs -> day for one decrement
   always_comb begin
      w_bmin    = (r_sec == 6'd0);
      w_bhrs    = w_bmin && (r_min == 6'd0);
      w_bday    = w_bhrs && (r_hrs == 5'd0);
      w_dec_sec = w_bmin ? 6'd59 : r_sec - 6'd1;
      w_dec_min = r_min;
      if (w_bmin) w_dec_min = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
      w_dec_hrs = r_hrs;
      if (w_bhrs) w_dec_hrs = (r_hrs == 5'd0) ? 5'd23 : r_hrs - 5'd1;
      w_dec_day = w_bday ? r_day - 5'd1 : r_day;
   end

   // Next state and datapath: clear > load > pause > start > tick
   always_comb begin
      w_state_nxt = r_state;
      w_day_nxt   = r_day;
      w_hrs_nxt   = r_hrs;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;
      w_pre_nxt   = r_pre;
      w_exp_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      w_rl_day_nxt = r_rl_day;
      w_rl_hrs_nxt = r_rl_hrs;
      w_rl_min_nxt = r_rl_min;
      w_rl_sec_nxt = r_rl_sec;
`endif
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_day_nxt   = '0;
         w_hrs_nxt   = '0;
         w_min_nxt   = '0;
         w_sec_nxt   = '0;
         w_pre_nxt   = PRE_RELOAD;
      end else if (w_fire) begin
         if (w_load_ok) begin
            w_state_nxt = S_IDLE;
            w_day_nxt   = load_day;
            w_hrs_nxt   = load_hrs;
            w_min_nxt   = load_min;
            w_sec_nxt   = load_sec;
`ifdef TIMER_AUTO_RELOAD_EN
            w_rl_day_nxt = load_day;
            w_rl_hrs_nxt = load_hrs;
            w_rl_min_nxt = load_min;
            w_rl_sec_nxt = load_sec;
`endif
         end else begin
            w_err_nxt = 1'b1;
         end
      end else if (r_state == S_RUN) begin
         // The prescaler keeps running on the pause edge; only the tick is dropped
         if (r_pre != '0) begin
            w_pre_nxt = r_pre - PW'(1);
         end else begin
            w_pre_nxt = PRE_RELOAD;
            if (!pause) begin
               if (w_le1) begin
                  w_exp_nxt   = 1'b1;
                  w_state_nxt = S_DONE;
                  w_day_nxt   = '0;
                  w_hrs_nxt   = '0;
                  w_min_nxt   = '0;
                  w_sec_nxt   = '0;
`ifdef TIMER_AUTO_RELOAD_EN
                  if (w_rl_nz) begin
                     w_state_nxt = S_RUN;
                     w_day_nxt   = r_rl_day;
                     w_hrs_nxt   = r_rl_hrs;
                     w_min_nxt   = r_rl_min;
                     w_sec_nxt   = r_rl_sec;
                  end
`endif
               end else begin
                  w_day_nxt = w_dec_day;
                  w_hrs_nxt = w_dec_hrs;
                  w_min_nxt = w_dec_min;
                  w_sec_nxt = w_dec_sec;
               end
            end
         end
         if (pause) w_state_nxt = S_PAUSED;
      end else if (!pause && start && w_nonzero &&
                   (r_state == S_IDLE || r_state == S_PAUSED)) begin
         w_state_nxt = S_RUN;
         if (r_state == S_IDLE) w_pre_nxt = PRE_RELOAD;
      end
   end

   // State, counts, prescaler and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_day      <= '0;
         r_hrs      <= '0;
         r_min      <= '0;
         r_sec      <= '0;
         r_pre      <= PRE_RELOAD;
         r_expired  <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_day      <= w_day_nxt;
         r_hrs      <= w_hrs_nxt;
         r_min      <= w_min_nxt;
         r_sec      <= w_sec_nxt;
         r_pre      <= w_pre_nxt;
         r_expired  <= w_exp_nxt;
         r_load_err <= w_err_nxt;
      end
   end

`ifdef TIMER_AUTO_RELOAD_EN
   // Reload copy of the last accepted load; survives clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rl_day <= '0;
         r_rl_hrs <= '0;
         r_rl_min <= '0;
         r_rl_sec <= '0;
      end else begin
         r_rl_day <= w_rl_day_nxt;
         r_rl_hrs <= w_rl_hrs_nxt;
         r_rl_min <= w_rl_min_nxt;
         r_rl_sec <= w_rl_sec_nxt;
      end
   end
`endif

   assign day      = r_day;
   assign hrs      = r_hrs;
   assign min      = r_min;
   assign sec      = r_sec;
   assign busy     = (r_state == S_RUN);
   assign expired  = r_expired;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench, two instances (TICK_DIV=1 and TICK_DIV=4, MAX_DAYS=20).
// Stimulus queues cycle-stamped expectations; a monitor pops and compares at negedge.
module tb_countdown_timer;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk, rst;
   logic       load_valid, start, pause, clear;
   logic [4:0] load_day, load_hrs;
   logic [5:0] load_min, load_sec;

   logic       a_rdy, a_err, a_busy, a_exp;
   logic [4:0] a_day, a_hrs;
   logic [5:0] a_min, a_sec;
   logic       b_rdy, b_err, b_busy, b_exp;
   logic [4:0] b_day, b_hrs;
   logic [5:0] b_min, b_sec;

   countdown_timer #(.TICK_DIV(1), .MAX_DAYS(31)) u_dut1 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(a_rdy),
      .load_day(load_day), .load_hrs(load_hrs), .load_min(load_min),
      .load_sec(load_sec), .load_err(a_err), .start(start), .pause(pause),
      .clear(clear), .day(a_day), .hrs(a_hrs), .min(a_min), .sec(a_sec),
      .busy(a_busy), .expired(a_exp)
   );

   countdown_timer #(.TICK_DIV(4), .MAX_DAYS(20)) u_dut4 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(b_rdy),
      .load_day(load_day), .load_hrs(load_hrs), .load_min(load_min),
      .load_sec(load_sec), .load_err(b_err), .start(start), .pause(pause),
      .clear(clear), .day(b_day), .hrs(b_hrs), .min(b_min), .sec(b_sec),
      .busy(b_busy), .expired(b_exp)
   );

   typedef struct {
      int          cyc;
      bit          dut;
      logic [25:0] val;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   base;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d checks pending", q.size());
      $fatal(1, "watchdog");
   end

   // dut=0 -> TICK_DIV=1 instance, dut=1 -> TICK_DIV=4 instance
   task automatic ex(input int at, input bit dut, input string nm,
                     input logic [4:0] d, input logic [4:0] h,
                     input logic [5:0] m, input logic [5:0] s,
                     input logic bz, input logic e, input logic er,
                     input logic rd);
      exp_t x;
      int   i;
      x.cyc = at;
      x.dut = dut;
      x.val = {d, h, m, s, bz, e, er, rd};
      x.nm  = nm;
      i = q.size();
      while (i > 0 && q[i-1].cyc > at) i--;
      q.insert(i, x);
   endtask

   // Monitor: compare every expectation stamped for this cycle
   initial forever begin
      exp_t        e;
      logic [25:0] o;
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         o = e.dut ? {b_day, b_hrs, b_min, b_sec, b_busy, b_exp, b_err, b_rdy}
                   : {a_day, a_hrs, a_min, a_sec, a_busy, a_exp, a_err, a_rdy};
         n_tests++;
         if (e.cyc != cyc || o !== e.val) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d:%0d:%0d:%0d b/e/er/r=%b want %0d:%0d:%0d:%0d b/e/er/r=%b",
                     e.nm, cyc, o[25:21], o[20:16], o[15:10], o[9:4], o[3:0],
                     e.val[25:21], e.val[20:16], e.val[15:10], e.val[9:4], e.val[3:0]);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic [4:0] d, input logic [4:0] h,
                           input logic [5:0] m, input logic [5:0] s);
      load_valid = 1'b1;
      load_day   = d;
      load_hrs   = h;
      load_min   = m;
      load_sec   = s;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      nxt();
      clear = 1'b0;
   endtask

   // Load, start, one tick on the TICK_DIV=1 instance, then clear while running
   task automatic borrow(input string nm,
                         input logic [4:0] d, input logic [4:0] h,
                         input logic [5:0] m, input logic [5:0] s,
                         input logic [4:0] ed, input logic [4:0] eh,
                         input logic [5:0] em, input logic [5:0] es);
      do_clear();
      set_load(d, h, m, s);
      ex(cyc + 1, 0, {nm, "_load"}, d, h, m, s, 0, 0, 0, 1);
      nxt();
      load_valid = 1'b0;
      start = 1'b1;
      ex(cyc + 1, 0, {nm, "_run"}, d, h, m, s, 1, 0, 0, 0);
      ex(cyc + 2, 0, {nm, "_tick"}, ed, eh, em, es, 1, 0, 0, 0);
      nxt();
      nxt();
      start = 1'b0;
      clear = 1'b1;
      ex(cyc + 1, 0, {nm, "_clr"}, 0, 0, 0, 0, 0, 0, 0, 1);
      nxt();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {load_valid, start, pause, clear} = '0;
      set_load(0, 0, 0, 0);
      load_valid = 1'b0;
      nxt();
      nxt();
      n_tests++;
      if ({a_day, a_hrs, a_min, a_sec, b_day, b_hrs, b_min, b_sec} !== '0) begin
         n_fail++;
         $display("FAIL rst_cnt: counts not zero in reset");
      end
      n_tests++;
      if ({a_busy, b_busy, a_rdy, b_rdy} !== 4'b0011) begin
         n_fail++;
         $display("FAIL rst_flags: busy/ready=%b", {a_busy, b_busy, a_rdy, b_rdy});
      end
      ex(cyc, 0, "rst_a", 0, 0, 0, 0, 0, 0, 0, 1);
      ex(cyc, 1, "rst_b", 0, 0, 0, 0, 0, 0, 0, 1);
      nxt();
      rst = 1'b0;
      nxt();

      // 0:0:0:3 on TICK_DIV=1 counts down on consecutive cycles
      set_load(0, 0, 0, 3);
      ex(cyc + 1, 0, "t1_load", 0, 0, 0, 3, 0, 0, 0, 1);
      nxt();
      load_valid = 1'b0;
      start = 1'b1;
      base = cyc;
      ex(base + 1, 0, "t1_s3", 0, 0, 0, 3, 1, 0, 0, 0);
      ex(base + 2, 0, "t1_s2", 0, 0, 0, 2, 1, 0, 0, 0);
      ex(base + 3, 0, "t1_s1", 0, 0, 0, 1, 1, 0, 0, 0);
      ex(base + 4, 0, "t1_exp", 0, 0, 0, AR ? 6'd3 : 6'd0, AR, 1, 0, !AR);
      ex(base + 5, 0, "t1_done", 0, 0, 0, AR ? 6'd2 : 6'd0, AR, 0, 0, !AR);
      repeat (5) nxt();
      start = 1'b0;

      borrow("t2_day", 1, 0, 0, 0, 0, 23, 59, 59);
      borrow("t2_hrs", 0, 1, 0, 0, 0, 0, 59, 59);
      borrow("t2_min", 0, 0, 5, 0, 0, 0, 4, 59);
      borrow("t2_mix", 3, 10, 0, 7, 3, 10, 0, 6);

      // Out-of-range loads leave everything unchanged and pulse load_err
      do_clear();
      set_load(0, 0, 1, 2);
      ex(cyc + 1, 0, "t3_ok", 0, 0, 1, 2, 0, 0, 0, 1);
      nxt();
      set_load(0, 0, 1, 60);
      ex(cyc + 1, 0, "t3_sec60", 0, 0, 1, 2, 0, 0, 1, 1);
      nxt();
      set_load(0, 24, 0, 0);
      ex(cyc + 1, 0, "t3_hrs24", 0, 0, 1, 2, 0, 0, 1, 1);
      nxt();
      set_load(0, 0, 60, 0);
      ex(cyc + 1, 0, "t3_min60", 0, 0, 1, 2, 0, 0, 1, 1);
      nxt();
      set_load(21, 0, 0, 0);
      ex(cyc + 1, 1, "t3_day21", 0, 0, 1, 2, 0, 0, 1, 1);
      nxt();
      set_load(20, 23, 59, 59);
      start = 1'b1;
      ex(cyc + 1, 1, "t3_max_ld_st", 20, 23, 59, 59, 0, 0, 0, 1);
      nxt();
      load_valid = 1'b0;
      ex(cyc + 1, 1, "t3_start", 20, 23, 59, 59, 1, 0, 0, 0);
      ex(cyc + 5, 1, "t3_tick4", 20, 23, 59, 58, 1, 0, 0, 0);
      repeat (5) nxt();
      start = 1'b0;

      // TICK_DIV=4: pause freezes count and prescaler, resume ticks 2 cycles later
      do_clear();
      set_load(0, 0, 0, 5);
      nxt();
      load_valid = 1'b0;
      start = 1'b1;
      base = cyc;
      ex(base + 1, 1, "t4_run", 0, 0, 0, 5, 1, 0, 0, 0);
      ex(base + 3, 1, "t4_paused", 0, 0, 0, 5, 0, 0, 0, 1);
      ex(base + 12, 1, "t4_hold", 0, 0, 0, 5, 0, 0, 0, 1);
      ex(base + 13, 1, "t4_resume", 0, 0, 0, 5, 1, 0, 0, 0);
      ex(base + 14, 1, "t4_pre", 0, 0, 0, 5, 1, 0, 0, 0);
      ex(base + 15, 1, "t4_tick1", 0, 0, 0, 4, 1, 0, 0, 0);
      ex(base + 18, 1, "t4_noload", 0, 0, 0, 4, 1, 0, 0, 0);
      ex(base + 19, 1, "t4_tick2", 0, 0, 0, 3, 1, 0, 0, 0);
      ex(base + 31, 1, "t4_exp", 0, 0, 0, AR ? 6'd5 : 6'd0, AR, 1, 0, !AR);
      ex(base + 32, 1, "t4_done", 0, 0, 0, AR ? 6'd5 : 6'd0, AR, 0, 0, !AR);
      for (int k = 1; k <= 33; k++) begin
         nxt();
         case (k)
            1:  start = 1'b0;
            2:  pause = 1'b1;
            12: begin pause = 1'b0; start = 1'b1; end
            13: start = 1'b0;
            16: set_load(0, 0, 9, 9);
            17: load_valid = 1'b0;
            default: ;
         endcase
      end

      // Asynchronous reset mid-run; start alone on a zero count does nothing
      do_clear();
      set_load(0, 0, 10, 30);
      nxt();
      load_valid = 1'b0;
      start = 1'b1;
      ex(cyc + 1, 1, "t5_run", 0, 0, 10, 30, 1, 0, 0, 0);
      nxt();
      nxt();
      start = 1'b0;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({b_day, b_hrs, b_min, b_sec} !== '0) begin
         n_fail++;
         $display("FAIL t5_async_cnt: %0d:%0d:%0d:%0d", b_day, b_hrs, b_min, b_sec);
      end
      n_tests++;
      if (b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_async_busy: busy=%b", b_busy);
      end
      ex(cyc, 0, "t5_arst_a", 0, 0, 0, 0, 0, 0, 0, 1);
      ex(cyc, 1, "t5_arst_b", 0, 0, 0, 0, 0, 0, 0, 1);
      nxt();
      rst = 1'b0;
      start = 1'b1;
      ex(cyc + 1, 0, "t5_zstart_a", 0, 0, 0, 0, 0, 0, 0, 1);
      ex(cyc + 2, 1, "t5_zstart_b", 0, 0, 0, 0, 0, 0, 0, 1);
      nxt();
      nxt();
      start = 1'b0;

`ifdef TIMER_AUTO_RELOAD_EN
      // Auto reload: 2,1,2,1 with expired on every reload and busy held
      do_clear();
      set_load(0, 0, 0, 2);
      nxt();
      load_valid = 1'b0;
      start = 1'b1;
      base = cyc;
      ex(base + 1, 0, "t6_s2", 0, 0, 0, 2, 1, 0, 0, 0);
      ex(base + 2, 0, "t6_s1", 0, 0, 0, 1, 1, 0, 0, 0);
      ex(base + 3, 0, "t6_rl1", 0, 0, 0, 2, 1, 1, 0, 0);
      ex(base + 4, 0, "t6_s1b", 0, 0, 0, 1, 1, 0, 0, 0);
      ex(base + 5, 0, "t6_rl2", 0, 0, 0, 2, 1, 1, 0, 0);
      repeat (5) nxt();
      start = 1'b0;
`endif

      repeat (3) nxt();
      while (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: expectation for cycle %0d never checked", q[0].nm, q[0].cyc);
         void'(q.pop_front());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
